// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard-unit state encoding, opcode map and
// the register-read decode used for load-use detection.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_DRAIN,
    ST_HALTED
  } hduState_t;

  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_AND = 4'h2;
  localparam logic [3:0] OPC_OR  = 4'h3;
  localparam logic [3:0] OPC_SLL = 4'h4;
  localparam logic [3:0] OPC_LW  = 4'h8;
  localparam logic [3:0] OPC_SW  = 4'h9;
  localparam logic [3:0] OPC_LUI = 4'hA;
  localparam logic [3:0] OPC_B   = 4'hC;
  localparam logic [3:0] OPC_JR  = 4'hD;
  localparam logic [3:0] OPC_HLT = 4'hF;

  // Rs is the first ALU operand, the load/store base and the jump target.
  function automatic logic reads_rs(input logic [3:0] opcode);
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SLL,
      OPC_LW, OPC_SW, OPC_JR: reads_rs = 1'b1;
      default:                reads_rs = 1'b0;
    endcase
  endfunction

  // Rt is the second ALU operand and the store data; B uses flags only.
  function automatic logic reads_rt(input logic [3:0] opcode);
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SW: reads_rt = 1'b1;
      default:                                   reads_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hdu_sat_counter.sv
// Saturating event counter for hazard-unit performance statistics.
module hdu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline stall/flush control: load-use bubbles, taken-branch flushes,
// HLT drain-and-halt, plus saturating stall/flush counters.
module hazard_detection_unit
  import cpu_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int OP_W         = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IF_ID_Valid,
  input  logic [OP_W-1:0]  IF_ID_Opcode,
  input  logic [REG_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_W-1:0] IF_ID_RegisterRt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  hduState_t          state, nextState;
  logic [DRAIN_W-1:0] drainCnt;
  logic               loadUse, isHlt;
  logic               pcWr, ifIdWr, flush, bubble, halt;
  logic               stallInc, flushInc;

  assign loadUse = IF_ID_Valid && ID_EX_MemRead && (ID_EX_RegisterRd != '0) &&
                   (((ID_EX_RegisterRd == IF_ID_RegisterRs) && reads_rs(IF_ID_Opcode)) ||
                    ((ID_EX_RegisterRd == IF_ID_RegisterRt) && reads_rt(IF_ID_Opcode)));
  assign isHlt   = IF_ID_Valid && (IF_ID_Opcode == OPC_HLT);

  always_comb begin
    pcWr      = 1'b1;
    ifIdWr    = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    halt      = 1'b0;
    stallInc  = 1'b0;
    flushInc  = 1'b0;
    nextState = state;
    unique case (state)
      ST_RUN, ST_STALL: begin
        nextState = ST_RUN;
        // A taken branch wins: anything in ID is wrong-path, so its LU/HLT is moot.
        if (EX_BranchTaken) begin
          flush    = 1'b1;
          bubble   = 1'b1;
          flushInc = 1'b1;
        end else if ((state == ST_RUN) && loadUse) begin
          pcWr      = 1'b0;
          ifIdWr    = 1'b0;
          bubble    = 1'b1;
          stallInc  = 1'b1;
          nextState = ST_STALL;
        end else if ((state == ST_RUN) && isHlt) begin
          pcWr      = 1'b0;
          ifIdWr    = 1'b0;
          nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (EX_BranchTaken) begin
          flush     = 1'b1;
          bubble    = 1'b1;
          flushInc  = 1'b1;
          nextState = ST_RUN;
        end else begin
          pcWr   = 1'b0;
          ifIdWr = 1'b0;
          bubble = 1'b1;
          if (drainCnt <= DRAIN_W'(1)) nextState = ST_HALTED;
        end
      end
      ST_HALTED: begin
        pcWr   = 1'b0;
        ifIdWr = 1'b0;
        bubble = 1'b1;
        halt   = 1'b1;
      end
      default: nextState = ST_RUN;
    endcase
  end

  // Controls are forced low for as long as reset is held.
  assign PC_Write     = rst_n && pcWr;
  assign IF_ID_Write  = rst_n && ifIdWr;
  assign IF_ID_Flush  = rst_n && flush;
  assign ID_EX_Bubble = rst_n && bubble;
  assign Halted       = rst_n && halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      drainCnt <= '0;
    end else begin
      state <= nextState;
      if ((state == ST_RUN) && (nextState == ST_DRAIN)) begin
        drainCnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if ((state == ST_DRAIN) && (drainCnt != '0)) begin
        drainCnt <= drainCnt - DRAIN_W'(1);
      end
    end
  end

  hdu_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallInc),
    .count (StallCount)
  );

  hdu_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flushInc),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit; a narrow-counter twin instance
// shares the stimulus so saturation is reachable in a short run.
module tb_hazard_detection_unit;

  logic        clk, rst_n;
  logic        ifIdValid, memRead, brTaken;
  logic [3:0]  opcode, rs, rt, rd;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExBubble, halted;
  logic [15:0] stallCount, flushCount;
  logic        sPcWrite, sIfIdWrite, sIfIdFlush, sIdExBubble, sHalted;
  logic [7:0]  sStallCount, sFlushCount;

  int total = 0;
  int bad   = 0;

  hazard_detection_unit dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_Valid(ifIdValid), .IF_ID_Opcode(opcode),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .ID_EX_MemRead(memRead),
    .ID_EX_RegisterRd(rd), .EX_BranchTaken(brTaken), .PC_Write(pcWrite),
    .IF_ID_Write(ifIdWrite), .IF_ID_Flush(ifIdFlush), .ID_EX_Bubble(idExBubble),
    .Halted(halted), .StallCount(stallCount), .FlushCount(flushCount)
  );

  hazard_detection_unit #(.CNT_W(8)) dutSat (
    .clk(clk), .rst_n(rst_n), .IF_ID_Valid(ifIdValid), .IF_ID_Opcode(opcode),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .ID_EX_MemRead(memRead),
    .ID_EX_RegisterRd(rd), .EX_BranchTaken(brTaken), .PC_Write(sPcWrite),
    .IF_ID_Write(sIfIdWrite), .IF_ID_Flush(sIfIdFlush), .ID_EX_Bubble(sIdExBubble),
    .Halted(sHalted), .StallCount(sStallCount), .FlushCount(sFlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Halted}
  localparam logic [4:0] O_RUN  = 5'b11000;
  localparam logic [4:0] O_LU   = 5'b00010;
  localparam logic [4:0] O_BR   = 5'b11110;
  localparam logic [4:0] O_HLT  = 5'b00000;
  localparam logic [4:0] O_DRN  = 5'b00010;
  localparam logic [4:0] O_HALT = 5'b00011;
  localparam logic [4:0] O_RST  = 5'b00000;

  typedef struct {
    logic       valid;
    logic [3:0] opc;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       mr;
    logic [3:0] rd;
    logic       br;
    logic [4:0] expOut;
    int         expStall;
    int         expFlush;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkOuts(input string name, input logic [4:0] exp);
    chk(name, 32'({pcWrite, ifIdWrite, ifIdFlush, idExBubble, halted}), 32'(exp));
  endtask

  task automatic chkCnt(input string name, input int expStall, input int expFlush);
    chk({name, ".stall"}, 32'(stallCount), expStall);
    chk({name, ".flush"}, 32'(flushCount), expFlush);
  endtask

  task automatic setIn(input logic v, input logic [3:0] o, input logic [3:0] s,
                       input logic [3:0] t, input logic m, input logic [3:0] d,
                       input logic b);
    ifIdValid = v; opcode = o; rs = s; rt = t; memRead = m; rd = d; brTaken = b;
  endtask

  task automatic idle();
    setIn(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  // Called at posedge+1: check combinational outputs mid-cycle, then advance.
  task automatic cyc(input string name, input logic [4:0] exp);
    #3;
    chkOuts(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            v     opc   rs    rt    mr    rd    br    out    st fl
    vecs[0]  = '{1'b1, 4'h0, 4'h3, 4'h5, 1'b1, 4'h3, 1'b0, O_LU,  1, 0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, O_RUN, 1, 0};
    vecs[2]  = '{1'b1, 4'h0, 4'h3, 4'h5, 1'b1, 4'h3, 1'b1, O_BR,  1, 1};
    vecs[3]  = '{1'b1, 4'h0, 4'h1, 4'h7, 1'b1, 4'h7, 1'b0, O_LU,  2, 1};
    vecs[4]  = '{1'b1, 4'h4, 4'h1, 4'h7, 1'b1, 4'h7, 1'b0, O_RUN, 2, 1};
    vecs[5]  = '{1'b1, 4'h9, 4'h1, 4'h7, 1'b1, 4'h7, 1'b0, O_LU,  3, 1};
    vecs[6]  = '{1'b1, 4'hA, 4'h7, 4'h7, 1'b1, 4'h7, 1'b0, O_RUN, 3, 1};
    vecs[7]  = '{1'b1, 4'h0, 4'h7, 4'h7, 1'b0, 4'h7, 1'b0, O_RUN, 3, 1};
    vecs[8]  = '{1'b0, 4'h0, 4'h7, 4'h7, 1'b1, 4'h7, 1'b0, O_RUN, 3, 1};
    vecs[9]  = '{1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h4, 1'b1, O_BR,  3, 2};
    vecs[10] = '{1'b1, 4'hD, 4'h5, 4'h0, 1'b1, 4'h5, 1'b0, O_LU,  4, 2};
    vecs[11] = '{1'b1, 4'hC, 4'h5, 4'h5, 1'b1, 4'h5, 1'b0, O_RUN, 4, 2};
    vecs[12] = '{1'b1, 4'h8, 4'h2, 4'h9, 1'b1, 4'h2, 1'b0, O_LU,  5, 2};

    rst_n = 1'b0;
    idle();
    #13;
    chkOuts("reset.outs", O_RST);
    chkCnt("reset", 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chkOuts("release.outs", O_RUN);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      setIn(vecs[i].valid, vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].mr,
            vecs[i].rd, vecs[i].br);
      cyc($sformatf("vec%0d.outs", i), vecs[i].expOut);
      chkCnt($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expFlush);
      idle();
      cyc($sformatf("vec%0d.after", i), O_RUN);
    end

    // LU is not re-evaluated in the stall cycle, then fires again in RUN.
    setIn(1'b1, 4'h0, 4'h3, 4'h1, 1'b1, 4'h3, 1'b0);
    cyc("stall.first", O_LU);
    cyc("stall.hold", O_RUN);
    chkCnt("stall.once", 6, 2);
    cyc("stall.again", O_LU);
    chkCnt("stall.again", 7, 2);
    idle();
    cyc("stall.idle", O_RUN);
    setIn(1'b1, 4'h0, 4'h3, 4'h1, 1'b1, 4'h3, 1'b0);
    cyc("stallbr.lu", O_LU);
    setIn(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    cyc("stallbr.br", O_BR);
    chkCnt("stallbr", 8, 3);
    idle();
    cyc("stallbr.idle", O_RUN);

    // HLT squashed by an older branch on the first drain cycle.
    setIn(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    cyc("hltbr.hlt", O_HLT);
    setIn(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    cyc("hltbr.flush", O_BR);
    idle();
    for (int i = 0; i < 3; i++) cyc($sformatf("hltbr.run%0d", i), O_RUN);
    chkCnt("hltbr", 8, 4);

    // Full drain, then halted regardless of later branches.
    setIn(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    cyc("halt.hlt", O_HLT);
    idle();
    cyc("halt.drain1", O_DRN);
    cyc("halt.drain2", O_DRN);
    for (int i = 0; i < 12; i++) begin
      brTaken = (i == 5);
      cyc($sformatf("halt.hold%0d", i), O_HALT);
    end
    idle();
    chkCnt("halt", 8, 4);

    // Asynchronous reset in the middle of a drain.
    resetDut();
    setIn(1'b1, 4'h0, 4'h6, 4'h1, 1'b1, 4'h6, 1'b0);
    cyc("rstdrn.lu", O_LU);
    idle();
    cyc("rstdrn.stall", O_RUN);
    chkCnt("rstdrn.pre", 1, 0);
    setIn(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    cyc("rstdrn.hlt", O_HLT);
    idle();
    #3;
    chkOuts("rstdrn.drain", O_DRN);
    rst_n = 1'b0;
    #1;
    chkOuts("rstdrn.inreset", O_RST);
    chkCnt("rstdrn.inreset", 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chkOuts("rstdrn.release", O_RUN);
    @(posedge clk);
    #1;
    cyc("rstdrn.run1", O_RUN);
    cyc("rstdrn.run2", O_RUN);

    // Saturation on the 8-bit twin; the 16-bit instance keeps counting.
    resetDut();
    for (int i = 0; i < 261; i++) begin
      setIn(1'b1, 4'h0, 4'h3, 4'h0, 1'b1, 4'h3, 1'b0);
      @(posedge clk);
      #1;
      idle();
      @(posedge clk);
      #1;
      if (i == 253) chk("sat.stall254", 32'(sStallCount), 32'h0FE);
    end
    chk("sat.stall8", 32'(sStallCount), 32'h0FF);
    chk("sat.stall16", 32'(stallCount), 261);
    brTaken = 1'b1;
    for (int i = 0; i < 261; i++) begin
      @(posedge clk);
      #1;
    end
    idle();
    chk("sat.flush8", 32'(sFlushCount), 32'h0FF);
    chk("sat.flush16", 32'(flushCount), 261);
    chk("sat.stallkeep", 32'(sStallCount), 32'h0FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
